matrix_vec_mac: RTL and testbench

//   Downstream consumer of the flattened matrix load buffer. Computes y = M * v for a
//   ROW x COL matrix of 32-bit signed words and a COL-element vector. Uses one

---
 rtl/matrix_vec_mac.sv | 142 ++++++++++++++
 tb/tb_matrix_vec_mac.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_vec_mac.sv
// Sequential matrix-vector multiply: y = M * v with one signed 32-bit MAC per clock.
// Operands are snapshotted on an accepted Start; results are written one row at a time.
module matrix_vec_mac #(
  parameter int row = 4,
  parameter int col = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    Start,
  input  logic                    Abort,
  input  logic [row*col*32-1:0]   Mat_in,
  input  logic [col*32-1:0]       Vec_in,
  output logic [row*32-1:0]       Result_out,
  output logic                    Busy_M,
  output logic                    Done,
  output logic                    Valid,
  output logic [1:0]              dbg_state_o
);

  localparam int RW = (row > 1) ? $clog2(row) : 1;
  localparam int CW = (col > 1) ? $clog2(col) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MAC  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [RW-1:0]           r_q, r_d;
  logic [CW-1:0]           c_q, c_d;
  logic [31:0]             acc_q, acc_d;
  logic [row*col*32-1:0]   mat_q, mat_d;
  logic [col*32-1:0]       vec_q, vec_d;
  logic [row*32-1:0]       res_q, res_d;
  logic                    valid_q, valid_d;

  logic [31:0]             m_sel;
  logic [31:0]             v_sel;
  logic [31:0]             prod;
  logic [31:0]             sum;
  logic                    last_c;
  logic                    last_r;

  // Operand selection uses constant slices so any row/col (including 1) stays well-formed.
  always_comb begin
    m_sel = '0;
    v_sel = '0;
    for (int i = 0; i < row; i++) begin
      for (int j = 0; j < col; j++) begin
        if (r_q == RW'(i) && c_q == CW'(j)) m_sel = mat_q[(i*col+j)*32 +: 32];
      end
    end
    for (int j = 0; j < col; j++) begin
      if (c_q == CW'(j)) v_sel = vec_q[j*32 +: 32];
    end
  end

  // Low 32 bits of a signed product equal those of the unsigned product.
  assign prod   = m_sel * v_sel;
  assign sum    = acc_q + prod;
  assign last_c = (c_q == CW'(col - 1));
  assign last_r = (r_q == RW'(row - 1));

  // Start is a request; it is taken only on an edge where Busy_M is low, never queued.
  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    c_d     = c_q;
    acc_d   = acc_q;
    mat_d   = mat_q;
    vec_d   = vec_q;
    res_d   = res_q;
    valid_d = valid_q;
    case (state_q)
      S_IDLE: begin
        if (Start) begin
          mat_d   = Mat_in;
          vec_d   = Vec_in;
          r_d     = '0;
          c_d     = '0;
          acc_d   = '0;
          valid_d = 1'b0;
          state_d = S_MAC;
        end
      end
      S_MAC: begin
        if (Abort) begin
          valid_d = 1'b0;
          state_d = S_IDLE;
        end else if (last_c) begin
          for (int i = 0; i < row; i++) begin
            if (r_q == RW'(i)) res_d[i*32 +: 32] = sum;
          end
          acc_d = '0;
          c_d   = '0;
          if (last_r) begin
            r_d     = '0;
            valid_d = 1'b1;
            state_d = S_DONE;
          end else begin
            r_d = r_q + 1'b1;
          end
        end else begin
          acc_d = sum;
          c_d   = c_q + 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      r_q     <= '0;
      c_q     <= '0;
      acc_q   <= '0;
      mat_q   <= '0;
      vec_q   <= '0;
      res_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      c_q     <= c_d;
      acc_q   <= acc_d;
      mat_q   <= mat_d;
      vec_q   <= vec_d;
      res_q   <= res_d;
      valid_q <= valid_d;
    end
  end

  assign Result_out  = res_q;
  assign Busy_M      = (state_q != S_IDLE);
  assign Done        = (state_q == S_DONE);
  assign Valid       = valid_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_matrix_vec_mac.sv
// Directed bench for matrix_vec_mac: 4x4 instance plus a 2x1 instance for the narrow case.
// Inputs are driven and outputs sampled on the falling edge.
module tb_matrix_vec_mac;

  localparam int R = 4;
  localparam int C = 4;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                reset;
  logic                Start;
  logic                Abort;
  logic [R*C*32-1:0]   Mat_in;
  logic [C*32-1:0]     Vec_in;
  logic [R*32-1:0]     Result_out;
  logic                Busy_M;
  logic                Done;
  logic                Valid;
  logic [1:0]          dbg_state;

  logic                s_start;
  logic [63:0]         s_mat;
  logic [31:0]         s_vec;
  logic [63:0]         s_res;
  logic                s_busy;
  logic                s_done;
  logic                s_valid;
  logic [1:0]          s_state;

  matrix_vec_mac #(.row(R), .col(C)) dut (
    .clk(clk), .reset(reset), .Start(Start), .Abort(Abort),
    .Mat_in(Mat_in), .Vec_in(Vec_in), .Result_out(Result_out),
    .Busy_M(Busy_M), .Done(Done), .Valid(Valid), .dbg_state_o(dbg_state)
  );

  matrix_vec_mac #(.row(2), .col(1)) dut_small (
    .clk(clk), .reset(reset), .Start(s_start), .Abort(1'b0),
    .Mat_in(s_mat), .Vec_in(s_vec), .Result_out(s_res),
    .Busy_M(s_busy), .Done(s_done), .Valid(s_valid), .dbg_state_o(s_state)
  );

  // scoreboard
  int          n_total = 0;
  int          n_bad   = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] mk4(input logic [31:0] a, input logic [31:0] b,
                                        input logic [31:0] c, input logic [31:0] d);
    return {d, c, b, a};
  endfunction

  task automatic push_exp(input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] c, input logic [31:0] d);
    exp_q.push_back(a);
    exp_q.push_back(b);
    exp_q.push_back(c);
    exp_q.push_back(d);
  endtask

  task automatic check_results(input string tag);
    logic [R*32-1:0] tmp;
    logic [31:0]     e;
    tmp = Result_out;
    for (int r = 0; r < R; r++) begin
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEADBEEF;
      check($sformatf("%s y%0d", tag, r), tmp[31:0], e);
      tmp = tmp >> 32;
    end
  endtask

  // driver tasks
  task automatic start_run(input string tag);
    Start = 1'b1;
    @(negedge clk);
    Start = 1'b0;
    check({tag, " busy"}, 32'(Busy_M), 32'd1);
  endtask

  task automatic wait_done(input string tag);
    int cyc;
    cyc = 0;
    while (Done !== 1'b1 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, " latency"}, 32'(cyc), 32'(R*C));
    check({tag, " valid@done"}, 32'(Valid), 32'd1);
    @(negedge clk);
    check({tag, " done low"}, 32'(Done), 32'd0);
    check({tag, " busy low"}, 32'(Busy_M), 32'd0);
  endtask

  logic [127:0] ident;
  int           dones;

  initial begin
    reset   = 1'b0;
    Start   = 1'b0;
    Abort   = 1'b0;
    Mat_in  = '0;
    Vec_in  = '0;
    s_start = 1'b0;
    s_mat   = '0;
    s_vec   = '0;
    ident   = mk4(32'd1, 32'd0, 32'd0, 32'd0);
    repeat (2) @(negedge clk);
    check("rst busy", 32'(Busy_M), 32'd0);
    check("rst done", 32'(Done), 32'd0);
    check("rst valid", 32'(Valid), 32'd0);
    check("rst state", 32'(dbg_state), 32'd0);
    push_exp(32'd0, 32'd0, 32'd0, 32'd0);
    check_results("rst");
    reset = 1'b1;
    @(negedge clk);

    // identity
    Mat_in = {mk4(0, 0, 0, 1), mk4(0, 0, 1, 0), mk4(0, 1, 0, 0), ident};
    Vec_in = mk4(1, 2, 3, 4);
    push_exp(1, 2, 3, 4);
    start_run("t1");
    wait_done("t1");
    check_results("t1");
    repeat (3) @(negedge clk);
    check("t1 valid held", 32'(Valid), 32'd1);

    // all -1
    Mat_in = {4{mk4(32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF)}};
    Vec_in = mk4(1, 2, 3, 4);
    push_exp(32'hFFFFFFF6, 32'hFFFFFFF6, 32'hFFFFFFF6, 32'hFFFFFFF6);
    start_run("t2");
    check("t2 valid cleared", 32'(Valid), 32'd0);
    wait_done("t2");
    check_results("t2");

    // truncation and wrap
    Mat_in = {mk4(0, 0, 0, 0), mk4(0, 0, 0, 0), mk4(0, 0, 0, 0),
              mk4(32'h7FFFFFFF, 32'h7FFFFFFF, 0, 0)};
    Vec_in = mk4(2, 1, 0, 0);
    push_exp(32'h7FFFFFFD, 0, 0, 0);
    start_run("t3");
    wait_done("t3");
    check_results("t3");

    // re-Start while busy, operands changed after acceptance
    Mat_in = {mk4(0, 0, 0, 5), mk4(0, 0, 4, 0), mk4(0, 3, 0, 0), mk4(2, 0, 0, 0)};
    Vec_in = mk4(10, 20, 30, 40);
    push_exp(32'h14, 32'h3C, 32'h78, 32'hC8);
    start_run("t4");
    Mat_in = {4{mk4(5, 5, 5, 5)}};
    Vec_in = mk4(1, 1, 1, 1);
    dones = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (Done) dones++;
      if (k == 18 || k == 20) check($sformatf("t4 idle k%0d", k), 32'(Busy_M), 32'd0);
      Start = (k == 3 || k == 16);
    end
    Start = 1'b0;
    check("t4 done count", 32'(dones), 32'd1);
    check_results("t4");

    // abort after two rows
    Mat_in = {mk4(13, 14, 15, 16), mk4(9, 10, 11, 12), mk4(5, 6, 7, 8), mk4(1, 2, 3, 4)};
    Vec_in = mk4(1, 1, 1, 1);
    push_exp(32'd10, 32'd26, 32'h78, 32'hC8);
    start_run("t5");
    dones = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (Done) dones++;
    end
    Abort = 1'b1;
    @(negedge clk);
    Abort = 1'b0;
    check("t5 busy", 32'(Busy_M), 32'd0);
    check("t5 valid", 32'(Valid), 32'd0);
    check("t5 done", 32'(Done + dones), 32'd0);
    check_results("t5");

    // reset mid-run
    Mat_in = {mk4(0, 0, 0, 1), mk4(0, 0, 1, 0), mk4(0, 1, 0, 0), ident};
    Vec_in = mk4(9, 8, 7, 6);
    start_run("t6");
    repeat (5) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check("t6 busy", 32'(Busy_M), 32'd0);
    check("t6 valid", 32'(Valid), 32'd0);
    check("t6 done", 32'(Done), 32'd0);
    push_exp(0, 0, 0, 0);
    check_results("t6 rst");
    reset = 1'b1;
    @(negedge clk);

    // Start with Abort in idle: Start wins
    Vec_in = mk4(7, 32'hFFFFFFFD, 0, 100);
    push_exp(7, 32'hFFFFFFFD, 0, 100);
    Abort = 1'b1;
    start_run("t7");
    Abort = 1'b0;
    wait_done("t7");
    check_results("t7");

    // 2x1 instance
    s_mat   = {32'hFFFFFFFE, 32'd3};
    s_vec   = 32'h10;
    s_start = 1'b1;
    @(negedge clk);
    s_start = 1'b0;
    check("s busy", 32'(s_busy), 32'd1);
    @(negedge clk);
    check("s not done", 32'(s_done), 32'd0);
    @(negedge clk);
    check("s done", 32'(s_done), 32'd1);
    check("s valid", 32'(s_valid), 32'd1);
    check("s y0", s_res[31:0], 32'h30);
    check("s y1", s_res[63:32], 32'hFFFFFFE0);
    @(negedge clk);
    check("s state idle", 32'(s_state), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
